// File: rtl/time_display_scan.sv
// Multiplexed 4-digit 7-segment scanner with per-frame snapshot, leading-zero blanking and error dash.
// Optional blink gating of Dig_En (driven by Wink) is built only when DISPLAY_BLINK_EN is defined.
module time_display_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 256
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] B_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic       A_Light,
  input  logic       B_Light,
  input  logic       Wink,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [3:0] Dig_En,
  output logic       Frame_Start,
  output logic       Bcd_Err
);

  localparam int PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: seg = 7'h40;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  function automatic logic is_bcd_err(input logic [3:0] code);
    return (code >= 4'hA) && (code <= 4'hE);
  endfunction

  logic [PS_W-1:0] prescale;
  logic [1:0]      slot;
  logic            load_pending;
  logic [17:0]     shadow_p0;
  logic            tick;
  logic            load;
  logic            vld_p0;
  logic            blink_on;

  assign tick   = (prescale == PS_LAST);
  assign load   = load_pending | (tick & (slot == 2'd3));
  assign vld_p0 = ~load_pending;

  // Stage 0: scan timing and frame snapshot
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      prescale     <= '0;
      slot         <= 2'd0;
      load_pending <= 1'b1;
      shadow_p0    <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;
      if (tick) slot <= slot + 2'd1;
      if (load) begin
        shadow_p0    <= {B_Time_H, B_Time_L, A_Time_H, A_Time_L, B_Light, A_Light};
        load_pending <= 1'b0;
      end
    end
  end

  logic [3:0] code_p0;
  logic [6:0] seg_p0;
  logic       dp_p0;
  logic       err_p0;
  logic [3:0] dig_p0;

  always_comb begin
    code_p0 = shadow_p0[5:2];
    case (slot)
      2'd1:    code_p0 = shadow_p0[9:6];
      2'd2:    code_p0 = shadow_p0[13:10];
      2'd3:    code_p0 = shadow_p0[17:14];
      default: code_p0 = shadow_p0[5:2];
    endcase
    // Odd slots are tens digits: a zero there is a leading zero and stays dark.
    seg_p0 = (slot[0] && (code_p0 == 4'h0)) ? 7'h00 : seg_decode(code_p0);
    err_p0 = is_bcd_err(code_p0);
    dp_p0  = slot[1] ? shadow_p0[1] : shadow_p0[0];
    dig_p0 = 4'b0001 << slot;
  end

`ifdef DISPLAY_BLINK_EN
  localparam int FC_W = $clog2(BLINK_DIV + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_DIV - 1);

  logic [FC_W-1:0] frame_cnt;
  logic            phase;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (!Wink) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (load) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Live Wink lets a cleared request re-enable the digits on the very next edge.
  assign blink_on = ~Wink | phase;
`else
  logic unused_blink;
  assign unused_blink = Wink ^ (BLINK_DIV < 1);
  assign blink_on     = 1'b1;
`endif

  logic [6:0] seg_p1;
  logic       dp_p1;
  logic [3:0] dig_p1;
  logic       fs_p1;
  logic       err_p1;

  // Stage 1: registered display outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      seg_p1 <= '0;
      dp_p1  <= 1'b0;
      dig_p1 <= '0;
      fs_p1  <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      seg_p1 <= vld_p0 ? seg_p0 : 7'h00;
      dp_p1  <= vld_p0 & dp_p0;
      dig_p1 <= vld_p0 ? (dig_p0 & {4{blink_on}}) : 4'b0000;
      err_p1 <= vld_p0 & err_p0;
      fs_p1  <= load;
    end
  end

  assign Seg         = seg_p1;
  assign Dp          = dp_p1;
  assign Dig_En      = dig_p1;
  assign Frame_Start = fs_p1;
  assign Bcd_Err     = err_p1;

endmodule
